lcd_rgb_rx: RTL and testbench

- Receive side of the RGB LCD DE-mode interface. Accepts a DE-qualified RGB888 stream in which hs/vs are tied high.
- Recovers frame and line boundaries from DE alone, regenerates per-pixel x/y coordinates, and measures active resolution.
- Used for loopback checking of the LCD timing path and for capturing an external RGB source into the display pipeline.

---
 rtl/lcd_rgb_rx.sv | 217 +++++++++++++++++++++
 tb/tb_lcd_rgb_rx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_rx.sv
// DE-only RGB888 receiver: rebuilds frame/line timing, pixel coordinates and measured resolution.
// Define LCD_RX_ID_DECODE_EN to build the panel-ID decode on lcd_id.
module lcd_rgb_rx #(
  parameter int VBLANK_GAP  = 2048,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_de,
  input  logic [23:0] in_rgb,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        sof,
  output logic        eof,
  output logic [10:0] h_res,
  output logic [10:0] v_res,
  output logic        res_valid,
  output logic        line_err,
  output logic [15:0] lcd_id
);

  localparam logic [15:0] GAP_LIM  = 16'(VBLANK_GAP);
  localparam logic [7:0]  LOCK_LIM = 8'(LOCK_FRAMES);
  localparam logic [10:0] XY_MAX   = 11'h7FF;

  typedef enum logic [1:0] {SEARCH, VBLANK, ACTIVE, HBLANK} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_gap_cnt;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [10:0] r_ref_len;
  logic [7:0]  r_stable_cnt;

  logic        w_gap_hit;
  logic        w_emit;
  logic        w_first;
  logic        w_new_line;
  logic        w_line_end;
  logic        w_frame_end;
  logic [10:0] w_px;
  logic [10:0] w_py;
  logic [10:0] w_h_new;
  logic [10:0] w_v_new;
  logic        w_x_ovf;
  logic        w_y_ovf;
  logic        w_len_err;
  logic        w_match;
  logic [7:0]  w_stable_next;

  always_ff @(posedge clk) begin
    if (rst)
      r_gap_cnt <= '0;
    else if (in_de)
      r_gap_cnt <= '0;
    else if (r_gap_cnt != 16'hFFFF)
      r_gap_cnt <= r_gap_cnt + 16'd1;
  end

  // A DE high in the very clock the gap limit is reached keeps the gap horizontal.
  assign w_gap_hit = !in_de && (r_gap_cnt >= GAP_LIM);

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= SEARCH;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_first      = 1'b0;
    w_new_line   = 1'b0;
    w_line_end   = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_gap_hit)
          w_state_next = VBLANK;
      end
      VBLANK: begin
        if (in_de) begin
          w_state_next = ACTIVE;
          w_emit       = 1'b1;
          w_first      = 1'b1;
        end
      end
      ACTIVE: begin
        if (in_de) begin
          w_emit = 1'b1;
        end else begin
          w_state_next = HBLANK;
          w_line_end   = 1'b1;
        end
      end
      HBLANK: begin
        if (in_de) begin
          w_state_next = ACTIVE;
          w_emit       = 1'b1;
          w_new_line   = 1'b1;
        end else if (w_gap_hit) begin
          w_state_next = VBLANK;
          w_frame_end  = 1'b1;
        end
      end
      default: w_state_next = SEARCH;
    endcase
  end

  // Coordinates of the pixel being accepted this clock; r_x/r_y hold the next ones.
  always_comb begin
    w_px = r_x;
    w_py = r_y;
    if (w_first) begin
      w_px = '0;
      w_py = '0;
    end else if (w_new_line) begin
      w_px = '0;
      w_py = (r_y == XY_MAX) ? XY_MAX : r_y + 11'd1;
    end
  end

  assign w_x_ovf   = w_emit && (w_px == XY_MAX);
  assign w_y_ovf   = w_new_line && (r_y == XY_MAX);
  assign w_len_err = w_line_end && (r_y != '0) && (r_x != r_ref_len);
  assign w_h_new   = r_ref_len;
  assign w_v_new   = (r_y == XY_MAX) ? XY_MAX : r_y + 11'd1;
  assign w_match   = (w_h_new == h_res) && (w_v_new == v_res);

  always_comb begin
    w_stable_next = 8'd1;
    if (line_err)
      w_stable_next = 8'd0;
    else if (w_match)
      w_stable_next = (r_stable_cnt >= LOCK_LIM) ? LOCK_LIM : r_stable_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      pix_valid <= w_emit;
      sof       <= w_first;
      if (w_emit) begin
        pix_data <= in_rgb;
        pix_x    <= w_px;
        pix_y    <= w_py;
        r_x      <= (w_px == XY_MAX) ? XY_MAX : w_px + 11'd1;
        r_y      <= w_py;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_len    <= '0;
      line_err     <= 1'b0;
      eof          <= 1'b0;
      h_res        <= '0;
      v_res        <= '0;
      r_stable_cnt <= '0;
      res_valid    <= 1'b0;
    end else begin
      eof <= w_frame_end;
      if (w_first) begin
        r_ref_len <= '0;
        line_err  <= 1'b0;
      end else begin
        if (w_line_end && (r_y == '0))
          r_ref_len <= r_x;
        if (w_x_ovf || w_y_ovf || w_len_err)
          line_err <= 1'b1;
      end
      if (w_frame_end) begin
        h_res        <= w_h_new;
        v_res        <= w_v_new;
        r_stable_cnt <= w_stable_next;
        res_valid    <= (w_stable_next >= LOCK_LIM);
      end
    end
  end

`ifdef LCD_RX_ID_DECODE_EN
  logic [15:0] w_id;

  always_comb begin
    w_id = 16'h0000;
    case ({w_h_new, w_v_new})
      {11'd480,  11'd272}: w_id = 16'h4342;
      {11'd800,  11'd480}: w_id = 16'h7084;
      {11'd1024, 11'd600}: w_id = 16'h7016;
      {11'd1280, 11'd800}: w_id = 16'h1018;
      default:             w_id = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      lcd_id <= '0;
    else if (w_frame_end)
      lcd_id <= (w_stable_next >= LOCK_LIM) ? w_id : 16'h0000;
  end
`else
  assign lcd_id = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Scoreboard bench for lcd_rgb_rx: pixels and frame results are queued as stimulus is
// driven and compared by a monitor when the receiver emits them.
module tb_lcd_rgb_rx;

  localparam int GAP  = 40;
  localparam int LOCK = 2;
  localparam int VB   = 60;

  typedef struct packed {
    logic [23:0] rgb;
    logic [10:0] x;
    logic [10:0] y;
    logic        sof;
  } pix_t;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        rv;
    logic        err;
  } frame_t;

  logic        clk;
  logic        rst;
  logic        in_de;
  logic [23:0] in_rgb;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        sof;
  logic        eof;
  logic [10:0] h_res;
  logic [10:0] v_res;
  logic        res_valid;
  logic        line_err;
  logic [15:0] lcd_id;

  int     checks;
  int     fails;
  pix_t   pixQ[$];
  frame_t frameQ[$];
  int     mPrevH;
  int     mPrevV;
  int     mStable;
  pix_t   monPix;
  frame_t monFrame;
  logic [15:0] monId;

  lcd_rgb_rx #(.VBLANK_GAP(GAP), .LOCK_FRAMES(LOCK)) dut (
    .clk(clk), .rst(rst), .in_de(in_de), .in_rgb(in_rgb),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eof(eof), .h_res(h_res), .v_res(v_res), .res_valid(res_valid),
    .line_err(line_err), .lcd_id(lcd_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LCD_RX_ID_DECODE_EN
  function automatic logic [15:0] idModel(input logic [10:0] h, input logic [10:0] v);
    if (h == 11'd480 && v == 11'd272) return 16'h4342;
    if (h == 11'd800 && v == 11'd480) return 16'h7084;
    if (h == 11'd1024 && v == 11'd600) return 16'h7016;
    if (h == 11'd1280 && v == 11'd800) return 16'h1018;
    return 16'h0000;
  endfunction
`endif

  // Monitor: every emitted pixel and every eof must match the next queued expectation.
  always @(negedge clk) begin
    if (pix_valid) begin
      checks++;
      if (pixQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_pixel: got x=%0d y=%0d, required no pixel", pix_x, pix_y);
      end else begin
        monPix = pixQ.pop_front();
        if ({pix_data, pix_x, pix_y, sof} !== monPix) begin
          fails++;
          $display("[TB] FAIL pixel: got rgb=%h x=%0d y=%0d sof=%b, required rgb=%h x=%0d y=%0d sof=%b",
                   pix_data, pix_x, pix_y, sof, monPix.rgb, monPix.x, monPix.y, monPix.sof);
        end
        if (monPix.sof) begin
          checks++;
          if (line_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL line_err_at_sof: got %b, required 0", line_err);
          end
        end
      end
    end else if (sof) begin
      checks++;
      fails++;
      $display("[TB] FAIL sof_without_pixel: got sof=1, required 0");
    end
    if (eof) begin
      checks++;
      if (frameQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_eof: got eof=1 h_res=%0d v_res=%0d, required no eof", h_res, v_res);
      end else begin
        monFrame = frameQ.pop_front();
`ifdef LCD_RX_ID_DECODE_EN
        monId = monFrame.rv ? idModel(monFrame.h, monFrame.v) : 16'h0000;
`else
        monId = 16'h0000;
`endif
        if ({h_res, v_res, res_valid, line_err, lcd_id} !== {monFrame, monId}) begin
          fails++;
          $display("[TB] FAIL eof_frame: got h=%0d v=%0d rv=%b err=%b id=%h, required h=%0d v=%0d rv=%b err=%b id=%h",
                   h_res, v_res, res_valid, line_err, lcd_id,
                   monFrame.h, monFrame.v, monFrame.rv, monFrame.err, monId);
        end
      end
    end
  end

  task automatic drive(input logic de, input logic [23:0] rgb);
    @(negedge clk);
    in_de  = de;
    in_rgb = rgb;
  endtask

  task automatic drive_line(input int len, input int y, input bit expectOut);
    pix_t        p;
    logic [23:0] rgb;
    for (int x = 0; x < len; x++) begin
      rgb = 24'($urandom);
      if (expectOut) begin
        p.rgb = rgb;
        p.x   = (x > 2047) ? 11'd2047 : 11'(x);
        p.y   = 11'(y);
        p.sof = (x == 0) && (y == 0);
        pixQ.push_back(p);
      end
      drive(1'b1, rgb);
    end
  endtask

  task automatic drive_frame(input int w, input int h, input int hb, input int vb,
                             input int badLine, input int badLen, input bit expectOut);
    int     len;
    int     firstLen;
    int     mh;
    bit     err;
    frame_t f;
    err      = 1'b0;
    firstLen = 0;
    for (int y = 0; y < h; y++) begin
      len = (y == badLine) ? badLen : w;
      if (y == 0) firstLen = len;
      else if (len != firstLen) err = 1'b1;
      if (len > 2047) err = 1'b1;
      drive_line(len, y, expectOut);
      if (y != h - 1) repeat (hb) drive(1'b0, 24'h0);
    end
    if (expectOut) begin
      mh = (firstLen > 2047) ? 2047 : firstLen;
      if (mh == mPrevH && h == mPrevV && !err)
        mStable = (mStable >= LOCK) ? LOCK : mStable + 1;
      else
        mStable = err ? 0 : 1;
      mPrevH = mh;
      mPrevV = h;
      f.h    = 11'(mh);
      f.v    = 11'(h);
      f.rv   = (mStable >= LOCK);
      f.err  = err;
      frameQ.push_back(f);
    end
    repeat (vb) drive(1'b0, 24'h0);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (frameQ.size() != 0 || pixQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_drained: got %0d frames %0d pixels pending, required 0 and 0",
               name, frameQ.size(), pixQ.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({pix_valid, pix_data, pix_x, pix_y, sof, eof} !== '0) begin
      fails++;
      $display("[TB] FAIL %s_pixel_outputs: got valid=%b data=%h x=%0d y=%0d sof=%b eof=%b, required all 0",
               name, pix_valid, pix_data, pix_x, pix_y, sof, eof);
    end
    checks++;
    if ({h_res, v_res, res_valid, line_err, lcd_id} !== '0) begin
      fails++;
      $display("[TB] FAIL %s_status_outputs: got h=%0d v=%0d rv=%b err=%b id=%h, required all 0",
               name, h_res, v_res, res_valid, line_err, lcd_id);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(1'b1, 24'($urandom));
    @(negedge clk);
    check_all_zero("reset");
    rst   = 1'b0;
    in_de = 1'b0;
    mPrevH  = 0;
    mPrevV  = 0;
    mStable = 0;
  endtask

  task automatic test_search_ignores();
    drive_frame(16, 3, 8, VB, -1, 0, 1'b0);
    check_drained("search");
  endtask

  task automatic test_basic_frames();
    repeat (3) drive_frame(16, 6, 8, VB, -1, 0, 1'b1);
    check_drained("basic");
  endtask

  task automatic test_long_hblank();
    repeat (2) drive_frame(20, 5, GAP, VB, -1, 0, 1'b1);
    check_drained("long_hblank");
  endtask

  task automatic test_short_line();
    drive_frame(12, 8, 6, VB, -1, 0, 1'b1);
    drive_frame(12, 8, 6, VB, -1, 0, 1'b1);
    drive_frame(12, 8, 6, VB, 5, 11, 1'b1);
    drive_frame(12, 8, 6, VB, -1, 0, 1'b1);
    drive_frame(12, 8, 6, VB, -1, 0, 1'b1);
    check_drained("short_line");
  endtask

  task automatic test_single_pixel_lines();
    drive_frame(1, 4, 5, VB, -1, 0, 1'b1);
    drive_frame(4, 4, 5, VB, 2, 1, 1'b1);
    check_drained("single_pixel");
  endtask

  task automatic test_res_switch();
    repeat (2) drive_frame(10, 6, 7, VB, -1, 0, 1'b1);
    repeat (2) drive_frame(14, 8, 7, VB, -1, 0, 1'b1);
    check_drained("res_switch");
  endtask

  task automatic test_midframe_reset();
    repeat (2) drive_frame(12, 6, 6, VB, -1, 0, 1'b1);
    drive_line(12, 0, 1'b1);
    repeat (6) drive(1'b0, 24'h0);
    drive_line(12, 1, 1'b1);
    repeat (6) drive(1'b0, 24'h0);
    drive_line(5, 2, 1'b1);
    @(negedge clk);
    rst    = 1'b1;
    in_rgb = 24'($urandom);
    @(negedge clk);
    check_all_zero("midframe_reset");
    check_drained("pre_reset");
    rst     = 1'b0;
    mPrevH  = 0;
    mPrevV  = 0;
    mStable = 0;
    drive_line(7, 2, 1'b0);
    for (int y = 3; y < 6; y++) begin
      repeat (6) drive(1'b0, 24'h0);
      drive_line(12, y, 1'b0);
    end
    repeat (VB) drive(1'b0, 24'h0);
    repeat (2) drive_frame(12, 6, 6, VB, -1, 0, 1'b1);
    check_drained("after_reset");
  endtask

  task automatic test_overflow();
    drive_frame(2100, 1, 8, VB, -1, 0, 1'b1);
    drive_frame(12, 4, 6, VB, -1, 0, 1'b1);
    check_drained("overflow");
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    in_de  = 1'b0;
    in_rgb = 24'h0;
    test_reset();
    test_search_ignores();
    test_basic_frames();
    test_long_hblank();
    test_short_line();
    test_single_pixel_lines();
    test_res_switch();
    test_midframe_reset();
    test_overflow();
    repeat (4) drive(1'b0, 24'h0);
    check_drained("final");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
